mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequencing controller and two-port arbiter in front of the ram512x8 memory block. Shares the single RAM between the instruction-fetch port (read-only) and the data port (read/write). Drives the MOV/ReadWrite/datatype/Address/DataIn handshake and synchronises the RAM's asynchronous MOC completion flag. Returns one-cycle ack/err pulses to the requesters.

Parameters:
TIMEOUT_CYCLES, 64, WAIT-state cycles without completion before the access is aborted with err (legal range 4..255).
ADDR_LIMIT, 512, first byte address outside the RAM. An access whose last byte is at or above this limit is rejected.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request, level; held until i_ack or i_err
i_addr  in  32  fetch byte address
i_ack  out  1  one-cycle pulse, fetch complete
i_err  out  1  one-cycle pulse, fetch failed; coincident with i_ack
i_rdata  out  32  fetch data; valid while i_ack=1
d_req  in  1  data request, level; held until d_ack or d_err
d_we  in  1  1=write, 0=read
d_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
d_addr  in  32  data byte address
d_wdata  in  32  write data; right-justified
d_ack  out  1  one-cycle pulse, data access complete
d_err  out  1  one-cycle pulse, data access failed; coincident with d_ack
d_rdata  out  32  read data, zero-extended; valid while d_ack=1
mem_mov  out  1  to RAM MOV
mem_rw  out  1  to RAM ReadWrite (1=read)
mem_addr  out  32  to RAM Address
mem_din  out  32  to RAM DataIn
mem_datatype  out  2  to RAM datatype
mem_moc  in  1  from RAM MOC; asynchronous
mem_dout  in  32  from RAM DataOut
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0, including mem_mov, acks, errs, rdata and busy. MOC synchroniser cleared. Round-robin pointer set to favour data.
- Fetch is always a word read (size 10, we=0).
- Datatype translation to RAM:
  - Read: byte→01, halfword→00, word→10.
  - Write: byte→00, halfword→01, word→10.
- Arbitration happens in IDLE only:
  - Single request: grant it.
  - Both requests: grant the port not granted last.
  - First contention after reset: data wins.
  - On grant, latch address, size, we and wdata into internal registers. Requester inputs are don't-care after the grant cycle.
- Pre-checks in the grant cycle: illegal size, or last byte ≥ ADDR_LIMIT, causes a direct transition to RESP with err=1. No RAM activity: mem_mov stays 0.
- States:
  - IDLE → SETUP on grant.
  - SETUP (1 cycle): drive mem_addr, mem_rw, mem_datatype, mem_din from latches; mem_mov=0.
  - ASSERT (1 cycle): mem_mov=1.
  - WAIT: mem_mov=1. mem_moc passes through a 2-flop synchroniser.
    - Completion counts only after synced MOC has been seen 0 at least once since ASSERT, so stale MOC from a prior access is ignored.
    - On synced MOC 0→1 qualified: capture mem_dout (reads) and go to RESP.
    - Timeout counter starts at 0 on entry. At TIMEOUT_CYCLES go to RESP with err=1 and rdata=0.
  - RESP (1 cycle): mem_mov=0; pulse ack (and err if set) on the granted port; drive rdata; update round-robin pointer; go to IDLE.
- mem_addr, mem_rw, mem_datatype and mem_din hold stable from SETUP through RESP.
- Minimum latency, grant to ack: 5 cycles (grant, SETUP, ASSERT, WAIT≥2, RESP → ack in cycle 5+).
- A request held high after its ack is treated as a new request in the next IDLE cycle. Back-to-back operation with no gap is permitted.
- rdata outputs are 0 whenever ack=0.
- A requester dropping req mid-access does not abort the access; the ack still pulses.
- Reset mid-access: mem_mov drops immediately and no ack is issued.

Optional Feature:
ALIGN_CHECK_EN.
- Defined: a halfword at an odd address, or a word at an address not divisible by 4, is rejected in the grant cycle with err (no RAM access).
- Undefined: unaligned accesses proceed to the RAM unchanged.

Test Plan:
- Data word write: d_we=1, size=10, d_addr=0x10, d_wdata=0xDEADBEEF → mem_datatype=10, mem_rw=0; d_ack pulses with d_err=0. A following data read at 0x10 returns d_rdata=0xDEADBEEF.
- Byte/halfword translation: read size 00 drives mem_datatype=01; read size 01 drives 00; write size 00 drives 00. A byte read at 0x13 after the write above returns 0x000000EF.
- Contention: i_req and d_req rise together after reset → data granted first, fetch next. Both held high → grants alternate d,i,d,i, each with exactly one ack.
- Timeout: mem_moc tied 0 with TIMEOUT_CYCLES=8 → d_ack=d_err=1 after 8 WAIT cycles, d_rdata=0, mem_mov back to 0.
- Range/illegal: d_addr=0x1FE with size=10, or size=11 → d_err pulse, mem_mov never asserted.
- Reset asserted during WAIT → all outputs 0 immediately, no ack. A fetch at 0x0 after reset completes normally; with ALIGN_CHECK_EN, a word read at 0x2 → err, no RAM access.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the mem_port_arbiter, its fetch/data requesters and the ram512x8 block.
// The arbiter takes the slave view; requesters and the RAM side together take the master view.
`timescale 1ns/1ps

interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic        i_err;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;

  logic        mem_mov;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [1:0]  mem_datatype;
  logic        mem_moc;
  logic [31:0] mem_dout;

  logic        busy;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_err, i_rdata,
    input  d_req, d_we, d_size, d_addr, d_wdata,
    output d_ack, d_err, d_rdata,
    output mem_mov, mem_rw, mem_addr, mem_din, mem_datatype,
    input  mem_moc, mem_dout,
    output busy
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_err, i_rdata,
    output d_req, d_we, d_size, d_addr, d_wdata,
    input  d_ack, d_err, d_rdata,
    input  mem_mov, mem_rw, mem_addr, mem_din, mem_datatype,
    output mem_moc, mem_dout,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin fetch/data arbiter and MOV/MOC sequencer for the ram512x8 block.
// Optional macro ALIGN_CHECK_EN rejects misaligned halfword/word accesses in the grant cycle.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ADDR_LIMIT     = 512
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned DATA_W  = 32;
  localparam logic [32:0] LIMIT33 = 33'(ADDR_LIMIT);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ASSERT,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  // Grant-time selection
  logic              grant_d, grant_i, grant_any;
  logic [31:0]       sel_addr;
  logic [1:0]        sel_size;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic              reject;

  // Latched access
  logic              gnt_d;
  logic [31:0]       lat_addr;
  logic [1:0]        lat_size;
  logic              lat_we;
  logic              lat_rd;
  logic [1:0]        lat_dtype;
  logic [DATA_W-1:0] lat_wdata;

  // Completion tracking
  logic              rr_fetch_last;
  logic              moc_s1, moc_s2;
  logic              moc_seen0;
  logic [7:0]        tcnt;
  logic              err_r;
  logic [DATA_W-1:0] rdata_r;
  logic              moc_done, timeout;

  function automatic logic [1:0] ram_dtype(input logic [1:0] size, input logic we);
    case (size)
      2'b00:   return we ? 2'b00 : 2'b01;
      2'b01:   return we ? 2'b01 : 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] byte_span(input logic [1:0] size);
    case (size)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // 33-bit sum so an address near 2^32 cannot wrap back into range
  function automatic logic in_range(input logic [31:0] addr, input logic [1:0] size);
    logic [32:0] last;
    last = {1'b0, addr} + {31'b0, byte_span(size)};
    return last < LIMIT33;
  endfunction

  function automatic logic [DATA_W-1:0] zext(input logic [DATA_W-1:0] d, input logic [1:0] size);
    case (size)
      2'b00:   return {24'b0, d[7:0]};
      2'b01:   return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

`ifdef ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [31:0] addr, input logic [1:0] size);
    return ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
  endfunction
`endif

  always_comb begin
    grant_d   = bus.d_req && (!bus.i_req || rr_fetch_last);
    grant_i   = bus.i_req && !grant_d;
    grant_any = grant_d || grant_i;
    sel_addr  = grant_d ? bus.d_addr  : bus.i_addr;
    sel_size  = grant_d ? bus.d_size  : 2'b10;
    sel_we    = grant_d && bus.d_we;
    sel_wdata = grant_d ? bus.d_wdata : '0;
`ifdef ALIGN_CHECK_EN
    reject    = (sel_size == 2'b11) || !in_range(sel_addr, sel_size) ||
                misaligned(sel_addr, sel_size);
`else
    reject    = (sel_size == 2'b11) || !in_range(sel_addr, sel_size);
`endif
  end

  // Completion needs a synced 0 seen since ASSERT, so a stale MOC high is ignored
  assign moc_done = (state == S_WAIT) && moc_seen0 && moc_s2;
  assign timeout  = (state == S_WAIT) && !moc_done && (tcnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (grant_any) state_nxt = reject ? S_RESP : S_SETUP;
      S_SETUP:  state_nxt = S_ASSERT;
      S_ASSERT: state_nxt = S_WAIT;
      S_WAIT:   if (moc_done || timeout) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_d         <= 1'b0;
      lat_addr      <= '0;
      lat_size      <= '0;
      lat_we        <= 1'b0;
      lat_rd        <= 1'b0;
      lat_dtype     <= '0;
      lat_wdata     <= '0;
      rr_fetch_last <= 1'b1;
      moc_s1        <= 1'b0;
      moc_s2        <= 1'b0;
      moc_seen0     <= 1'b0;
      tcnt          <= '0;
      err_r         <= 1'b0;
      rdata_r       <= '0;
    end else begin
      moc_s1 <= bus.mem_moc;
      moc_s2 <= moc_s1;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            gnt_d     <= grant_d;
            lat_addr  <= sel_addr;
            lat_size  <= sel_size;
            lat_we    <= sel_we;
            lat_rd    <= !sel_we;
            lat_dtype <= ram_dtype(sel_size, sel_we);
            lat_wdata <= sel_wdata;
            err_r     <= reject;
            rdata_r   <= '0;
          end
        end
        S_ASSERT: begin
          tcnt      <= '0;
          moc_seen0 <= !moc_s2;
        end
        S_WAIT: begin
          tcnt <= tcnt + 8'd1;
          if (!moc_s2) moc_seen0 <= 1'b1;
          if (moc_done) begin
            if (!lat_we) rdata_r <= zext(bus.mem_dout, lat_size);
          end else if (timeout) begin
            err_r   <= 1'b1;
            rdata_r <= '0;
          end
        end
        S_RESP: rr_fetch_last <= !gnt_d;
        default: ;
      endcase
    end
  end

  // Response outputs decode from state, so reset clears them at once
  assign bus.mem_mov      = (state == S_ASSERT) || (state == S_WAIT);
  assign bus.mem_rw       = lat_rd;
  assign bus.mem_addr     = lat_addr;
  assign bus.mem_din      = lat_wdata;
  assign bus.mem_datatype = lat_dtype;
  assign bus.busy         = (state != S_IDLE);

  assign bus.d_ack   = (state == S_RESP) && gnt_d;
  assign bus.d_err   = bus.d_ack && err_r;
  assign bus.d_rdata = bus.d_ack ? rdata_r : '0;
  assign bus.i_ack   = (state == S_RESP) && !gnt_d;
  assign bus.i_err   = bus.i_ack && err_r;
  assign bus.i_rdata = bus.i_ack ? rdata_r : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural big-endian ram512x8 model.
// Honors ALIGN_CHECK_EN when choosing expectations for misaligned accesses.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT_CYCLES(8), .ADDR_LIMIT(512)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // RAM model: raises MOC two falling edges into a MOV, drops it when MOV falls
  logic [7:0] ram [0:511] = '{default: 8'h00};
  bit         moc_en = 1'b1;
  int         ram_cnt = 0;

  always @(negedge clk) begin
    logic [8:0] a;
    a = bus.mem_addr[8:0];
    if (reset || !bus.mem_mov) begin
      bus.mem_moc  = 1'b0;
      bus.mem_dout = 32'h0;
      ram_cnt      = 0;
    end else if (moc_en && !bus.mem_moc) begin
      ram_cnt++;
      if (ram_cnt == 2) begin
        if (bus.mem_rw) begin
          case (bus.mem_datatype)
            2'b01:   bus.mem_dout = {24'h0, ram[a]};
            2'b00:   bus.mem_dout = {16'h0, ram[a], ram[a + 9'd1]};
            default: bus.mem_dout = {ram[a], ram[a + 9'd1], ram[a + 9'd2], ram[a + 9'd3]};
          endcase
        end else begin
          case (bus.mem_datatype)
            2'b00: ram[a] = bus.mem_din[7:0];
            2'b01: begin
              ram[a]        = bus.mem_din[15:8];
              ram[a + 9'd1] = bus.mem_din[7:0];
            end
            default: begin
              ram[a]        = bus.mem_din[31:24];
              ram[a + 9'd1] = bus.mem_din[23:16];
              ram[a + 9'd2] = bus.mem_din[15:8];
              ram[a + 9'd3] = bus.mem_din[7:0];
            end
          endcase
        end
        bus.mem_moc = 1'b1;
      end
    end
  end

  task automatic run_access(input bit is_d, input bit we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output bit got_ack, output bit got_err, output logic [31:0] got_rdata,
                            output bit mov_seen, output logic [1:0] dt, output bit rw,
                            output int mov_cycles);
    @(posedge clk); #1;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size;
      bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    got_ack = 0; got_err = 0; got_rdata = 0; mov_seen = 0; dt = 0; rw = 0; mov_cycles = 0;
    for (int c = 0; c < 40 && !got_ack; c++) begin
      @(posedge clk); #1;
      if (bus.mem_mov) begin
        mov_seen = 1; mov_cycles++; dt = bus.mem_datatype; rw = bus.mem_rw;
      end
      if (is_d ? bus.d_ack : bus.i_ack) begin
        got_ack   = 1;
        got_err   = is_d ? bus.d_err : bus.i_err;
        got_rdata = is_d ? bus.d_rdata : bus.i_rdata;
      end
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [1:0]  exp_dt;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ack, err, mov, rw;
    logic [31:0] rdata;
    logic [1:0]  dt;
    int          movc, nacks, overlap;
    logic [3:0]  order;

    vecs[0]  = '{1'b1, 2'b10, 32'h10,  32'hDEADBEEF, 1'b0, 2'b10, 32'h0};
    vecs[1]  = '{1'b0, 2'b10, 32'h10,  32'h0,        1'b0, 2'b10, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 2'b00, 32'h13,  32'h0,        1'b0, 2'b01, 32'h000000EF};
    vecs[3]  = '{1'b0, 2'b01, 32'h12,  32'h0,        1'b0, 2'b00, 32'h0000BEEF};
    vecs[4]  = '{1'b1, 2'b00, 32'h20,  32'h123456AB, 1'b0, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 2'b00, 32'h20,  32'h0,        1'b0, 2'b01, 32'h000000AB};
    vecs[6]  = '{1'b1, 2'b01, 32'h30,  32'hFFFF1234, 1'b0, 2'b01, 32'h0};
    vecs[7]  = '{1'b0, 2'b01, 32'h30,  32'h0,        1'b0, 2'b00, 32'h00001234};
    vecs[8]  = '{1'b1, 2'b10, 32'h1FC, 32'hCAFEF00D, 1'b0, 2'b10, 32'h0};
    vecs[9]  = '{1'b0, 2'b00, 32'h1FF, 32'h0,        1'b0, 2'b01, 32'h0000000D};
    vecs[10] = '{1'b0, 2'b10, 32'h1FE, 32'h0,        1'b1, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 2'b11, 32'h0,   32'h0,        1'b1, 2'b00, 32'h0};
    vecs[12] = '{1'b1, 2'b00, 32'h200, 32'h55,       1'b1, 2'b00, 32'h0};
    vecs[13] = '{1'b1, 2'b10, 32'h0,   32'h11223344, 1'b0, 2'b10, 32'h0};
`ifdef ALIGN_CHECK_EN
    vecs[14] = '{1'b0, 2'b01, 32'h11,  32'h0,        1'b1, 2'b00, 32'h0};
`else
    vecs[14] = '{1'b0, 2'b01, 32'h11,  32'h0,        1'b0, 2'b00, 32'h0000ADBE};
`endif

    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_size = 0; bus.d_addr = 0; bus.d_wdata = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",     bus.busy, 0);
    check("reset_mem_mov",  bus.mem_mov, 0);
    check("reset_acks",     {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 0);
    check("reset_d_rdata",  bus.d_rdata, 0);
    check("reset_i_rdata",  bus.i_rdata, 0);
    check("reset_mem_bus",  {bus.mem_rw, bus.mem_datatype, bus.mem_addr[28:0]}, 0);
    check("reset_mem_din",  bus.mem_din, 0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_access(1'b1, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                 ack, err, rdata, mov, dt, rw, movc);
      check($sformatf("v%0d_ack", i),   ack, 1);
      check($sformatf("v%0d_err", i),   err, vecs[i].exp_err);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_mov", i),   mov, !vecs[i].exp_err);
      if (!vecs[i].exp_err) begin
        check($sformatf("v%0d_dtype", i), dt, vecs[i].exp_dt);
        check($sformatf("v%0d_rw", i),    rw, !vecs[i].we);
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_idle_rdata", i), {bus.d_ack, bus.d_rdata[30:0]}, 0);
    end

    // Contention straight out of reset: data first, then strict alternation
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.i_addr = 32'h10;
    bus.d_we = 0; bus.d_size = 2'b00; bus.d_addr = 32'h20;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    nacks = 0; overlap = 0; order = 4'b0;
    for (int c = 0; c < 200 && nacks < 4; c++) begin
      @(posedge clk); #1;
      if (bus.d_ack && bus.i_ack) overlap++;
      if (bus.d_ack) begin
        order[3 - nacks] = 1'b1;
        check($sformatf("rr%0d_d_rdata", nacks), bus.d_rdata, 32'h000000AB);
        nacks++;
      end else if (bus.i_ack) begin
        check($sformatf("rr%0d_i_rdata", nacks), bus.i_rdata, 32'hDEADBEEF);
        nacks++;
      end
    end
    bus.i_req = 0; bus.d_req = 0;
    check("rr_ack_count", nacks, 4);
    check("rr_order_didi", order, 4'b1010);
    check("rr_overlap", overlap, 0);

    // Timeout with MOC stuck low: ASSERT plus 8 WAIT cycles of MOV
    moc_en = 1'b0;
    run_access(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, ack, err, rdata, mov, dt, rw, movc);
    check("to_ack", ack, 1);
    check("to_err", err, 1);
    check("to_rdata", rdata, 0);
    check("to_mov_cycles", movc, 9);
    check("to_mov_low_in_resp", bus.mem_mov, 0);

    // Reset during WAIT drops everything at once and no ack follows
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = 32'h10;
    movc = 0;
    for (int c = 0; c < 20 && movc < 3; c++) begin
      @(posedge clk); #1;
      if (bus.mem_mov) movc++;
    end
    check("rst_wait_reached", movc, 3);
    reset = 1'b1;
    #1;
    check("rst_mov_now", bus.mem_mov, 0);
    check("rst_busy_now", bus.busy, 0);
    check("rst_acks_now", {bus.d_ack, bus.d_err, bus.i_ack, bus.i_err}, 0);
    check("rst_addr_now", bus.mem_addr, 0);
    bus.d_req = 1'b0;
    moc_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    nacks = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.d_ack || bus.i_ack) nacks++;
    end
    check("rst_no_ack", nacks, 0);

    run_access(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, ack, err, rdata, mov, dt, rw, movc);
    check("f0_ack", ack, 1);
    check("f0_err", err, 0);
    check("f0_rdata", rdata, 32'h11223344);
    check("f0_dtype", dt, 2'b10);
    check("f0_rw", rw, 1);

    run_access(1'b0, 1'b0, 2'b10, 32'h2, 32'h0, ack, err, rdata, mov, dt, rw, movc);
    check("f2_ack", ack, 1);
`ifdef ALIGN_CHECK_EN
    check("f2_err", err, 1);
    check("f2_mov", mov, 0);
    check("f2_rdata", rdata, 0);
`else
    check("f2_err", err, 0);
    check("f2_mov", mov, 1);
    check("f2_rdata", rdata, 32'h33440000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
